// File: rtl/main_memory_if.sv
// CPU-to-main-memory bus: shared word address, level strobes, write data and registered read data.
// MEM_PARITY_EN adds the parity_err status line.
interface main_memory_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16
);
    logic [ADDR_W-1:0] adress;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] indata;
    logic [DATA_W-1:0] outdata;
`ifdef MEM_PARITY_EN
    logic              parity_err;

    modport master (output adress, read, write, indata, input outdata, parity_err);
    modport slave  (input adress, read, write, indata, output outdata, parity_err);
`else
    modport master (output adress, read, write, indata, input outdata);
    modport slave  (input adress, read, write, indata, output outdata);
`endif
endinterface

// File: rtl/main_memory.sv
// Single-port 2**ADDR_W x DATA_W synchronous RAM with one clock of registered read latency.
// Optional MEM_PARITY_EN stores an even-parity bit per word and flags mismatches on read.
module main_memory #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    main_memory_if.slave   bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] outdata_q;
    logic              wr_en;
    logic              rd_en;

    // Write wins over read; reset blocks both.
    assign wr_en = !rst && bus.write;
    assign rd_en = !rst && bus.read && !bus.write;

    // Array has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[bus.adress] <= bus.indata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outdata_q <= '0;
        end else if (rd_en) begin
            outdata_q <= mem[bus.adress];
        end
    end

    assign bus.outdata = outdata_q;

`ifdef MEM_PARITY_EN
    logic par_mem [DEPTH];
    logic parity_err_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            par_mem[bus.adress] <= ^bus.indata;
        end
    end

    // Stored bit plus recomputed parity of the data must be even.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else if (rd_en) begin
            parity_err_q <= (^mem[bus.adress]) ^ par_mem[bus.adress];
        end
    end

    assign bus.parity_err = parity_err_q;
`endif
endmodule

// File: tb/tb_main_memory.sv
// Bench for main_memory: directed vector table, sequential fill, randomized write/read
// against an array reference model, and the parity path when MEM_PARITY_EN is defined.
module tb_main_memory;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic clk;
    logic rst;

    main_memory_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    main_memory #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference: plain word array plus the value the read register should hold.
    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] model_out;

    typedef struct {
        logic              r;
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] exp_out;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one cycle of inputs, clock it, then update the reference model.
    task automatic step(input logic r, input logic rd, input logic wr,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        rst           = r;
        bus_if.read   = rd;
        bus_if.write  = wr;
        bus_if.adress = a;
        bus_if.indata = d;
        @(posedge clk);
        #1;
        if (r)       model_out = '0;
        else if (wr) model_mem[a] = d;
        else if (rd) model_out = model_mem[a];
    endtask

    initial begin
        rst           = 1'b1;
        bus_if.read   = 1'b0;
        bus_if.write  = 1'b0;
        bus_if.adress = '0;
        bus_if.indata = '0;
        model_out     = '0;
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 12'h000, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 12'h0A5, 16'hBEEF, 16'h0000};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 12'h0A5, 16'h0000, 16'hBEEF};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 12'h0A5, 16'h1111, 16'h0000};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 12'h0A5, 16'h0000, 16'hBEEF};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 12'h7FF, 16'h1234, 16'hBEEF};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 12'h7FF, 16'h0000, 16'h1234};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 12'h7FF, 16'h5555, 16'h1234};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 12'h7FF, 16'h0000, 16'h5555};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 12'hFFF, 16'hFFFF, 16'h5555};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 12'h000, 16'h0001, 16'h5555};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 12'hFFF, 16'h0000, 16'hFFFF};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 12'h123, 16'h9999, 16'hFFFF};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 12'h000, 16'h9999, 16'hFFFF};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 12'h000, 16'h0000, 16'h0001};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 12'h000, 16'hAAAA, 16'h0001};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 12'h000, 16'h0000, 16'hAAAA};

        // A0 check: only the reset row, outputs straight after reset
        step(1'b1, 1'b0, 1'b0, '0, '0);
        check("reset_out", bus_if.outdata, 16'h0000);
`ifdef MEM_PARITY_EN
        check("reset_perr", 16'(bus_if.parity_err), 16'h0000);
`endif

        // Directed vector table: reset priority, strobe collision, idle hold, boundaries.
        for (int i = 0; i < 17; i++) begin
            step(vecs[i].r, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d);
            check($sformatf("vec%0d", i), bus_if.outdata, vecs[i].exp_out);
        end

        // Sequential fill with write held high, then read back every address.
        for (int i = 0; i < int'(DEPTH); i++) step(1'b0, 1'b0, 1'b1, ADDR_W'(i), DATA_W'(i));
        for (int i = 0; i < int'(DEPTH); i++) begin
            step(1'b0, 1'b1, 1'b0, ADDR_W'(i), '0);
            check($sformatf("fill_rd_%0h", i), bus_if.outdata, DATA_W'(i));
        end

        // Randomized write-then-read plus occasional random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [ADDR_W-1:0] a;
            logic [DATA_W-1:0] d;
            a = ADDR_W'($urandom_range(0, DEPTH - 1));
            d = DATA_W'($urandom);
            step(1'b0, 1'($urandom_range(0, 1)), 1'b1, a, d);
            step(1'b0, 1'b1, 1'b0, a, '0);
            check("rand_rd", bus_if.outdata, d);
            if ((i % 50) == 0) begin
                step(1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                     ADDR_W'($urandom), DATA_W'($urandom));
                check("rand_mix", bus_if.outdata, model_out);
            end
        end

        // Reset leaves array contents intact.
        step(1'b0, 1'b0, 1'b1, 12'h0A5, 16'hBEEF);
        step(1'b0, 1'b1, 1'b0, 12'h0A5, '0);
        check("pre_rst_rd", bus_if.outdata, 16'hBEEF);
        step(1'b1, 1'b0, 1'b0, 12'h0A5, '0);
        check("mid_rst", bus_if.outdata, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 12'h0A5, '0);
        check("post_rst_rd", bus_if.outdata, 16'hBEEF);

`ifdef MEM_PARITY_EN
        step(1'b0, 1'b0, 1'b1, 12'h010, 16'h00F0);
        step(1'b0, 1'b1, 1'b0, 12'h010, '0);
        check("par_ok_data", bus_if.outdata, 16'h00F0);
        check("par_ok_err", 16'(bus_if.parity_err), 16'h0000);
        #3;
        dut.mem[16] = dut.mem[16] ^ 16'h0001;
        step(1'b0, 1'b1, 1'b0, 12'h010, '0);
        check("par_bad_data", bus_if.outdata, 16'h00F1);
        check("par_bad_err", 16'(bus_if.parity_err), 16'h0001);
        step(1'b0, 1'b0, 1'b0, 12'h000, '0);
        check("par_err_hold", 16'(bus_if.parity_err), 16'h0001);
        step(1'b1, 1'b0, 1'b0, 12'h000, '0);
        check("par_rst_err", 16'(bus_if.parity_err), 16'h0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
